// File: rtl/sparse_coo_mm_engine.sv
// Streaming COO sparse matrix multiply C = A * B: buffers both nonzero lists, sweeps every
// A x B entry pair through one MAC, then drains C row-major as dense or nonzero-only beats.
module sparse_coo_mm_engine #(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned M          = 4,
   parameter int unsigned N          = 4,
   parameter int unsigned K          = 4,
   parameter int unsigned MAX_NNZ    = 30,
   parameter int unsigned SPARSE_OUT = 0,
   parameter int unsigned ACC_W      = 2 * DATA_W + $clog2(N),
   localparam int unsigned MW = (M > 1) ? $clog2(M) : 1,
   localparam int unsigned NW = (N > 1) ? $clog2(N) : 1,
   localparam int unsigned KW = (K > 1) ? $clog2(K) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   input  logic              a_valid_i,
   output logic              a_ready_o,
   input  logic [MW-1:0]     a_row_i,
   input  logic [NW-1:0]     a_col_i,
   input  logic [DATA_W-1:0] a_val_i,
   input  logic              a_last_i,
   input  logic              b_valid_i,
   output logic              b_ready_o,
   input  logic [NW-1:0]     b_row_i,
   input  logic [KW-1:0]     b_col_i,
   input  logic [DATA_W-1:0] b_val_i,
   input  logic              b_last_i,
   output logic              c_valid_o,
   input  logic              c_ready_i,
   output logic [MW-1:0]     c_row_o,
   output logic [KW-1:0]     c_col_o,
   output logic [ACC_W-1:0]  c_val_o,
   output logic              c_last_o,
   output logic              err_index_o,
   output logic              err_overflow_o
);

   localparam int unsigned IW = (MAX_NNZ > 1) ? $clog2(MAX_NNZ) : 1;
   localparam int unsigned CW = $clog2(MAX_NNZ + 1);

   localparam logic [MW:0]   MLim   = M[MW:0];
   localparam logic [NW:0]   NLim   = N[NW:0];
   localparam logic [KW:0]   KLim   = K[KW:0];
   localparam logic [CW-1:0] NnzMax = MAX_NNZ[CW-1:0];
   localparam logic [MW-1:0] MLast  = MW'(M - 1);
   localparam logic [KW-1:0] KLast  = KW'(K - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StCompute, StDrain} state_e;

   state_e state_q, state_d;

   // Entry buffers; only slots below the matching count are ever read.
   logic        [MW-1:0]     a_row_q [MAX_NNZ];
   logic        [NW-1:0]     a_col_q [MAX_NNZ];
   logic signed [DATA_W-1:0] a_val_q [MAX_NNZ];
   logic        [NW-1:0]     b_row_q [MAX_NNZ];
   logic        [KW-1:0]     b_col_q [MAX_NNZ];
   logic signed [DATA_W-1:0] b_val_q [MAX_NNZ];

   logic signed [ACC_W-1:0]  acc_q [M][K];

   logic [CW-1:0] a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
   logic          a_done_q, a_done_d, b_done_q, b_done_d;
   logic [IW-1:0] i_q, i_d, j_q, j_d;
   logic [MW-1:0] r_q, r_d;
   logic [KW-1:0] cc_q, cc_d;
   logic          done_q, done_d;
   logic          err_idx_q, err_idx_d, err_ovf_q, err_ovf_d;

   logic a_fire, b_fire, a_in_range, b_in_range, a_store, b_store;
   logic acc_clr, acc_we, more_nz, at_end;
   logic [IW-1:0] i_last, j_last;
   logic [MW-1:0] acc_row;
   logic [KW-1:0] acc_col;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    prod_ext;
   logic signed [ACC_W-1:0]    cur_val;

   assign a_ready_o = (state_q == StLoad) && !a_done_q;
   assign b_ready_o = (state_q == StLoad) && !b_done_q;
   assign a_fire    = a_valid_i && a_ready_o;
   assign b_fire    = b_valid_i && b_ready_o;

   assign a_in_range = ({1'b0, a_row_i} < MLim) && ({1'b0, a_col_i} < NLim);
   assign b_in_range = ({1'b0, b_row_i} < NLim) && ({1'b0, b_col_i} < KLim);

   assign i_last   = IW'(a_cnt_q - 1'b1);
   assign j_last   = IW'(b_cnt_q - 1'b1);
   assign acc_row  = a_row_q[i_q];
   assign acc_col  = b_col_q[j_q];
   assign prod     = a_val_q[i_q] * b_val_q[j_q];
   assign prod_ext = ACC_W'(prod);

   assign cur_val = acc_q[r_q][cc_q];
   assign at_end  = (r_q == MLast) && (cc_q == KLast);

   // Lookahead so the last nonzero beat can carry c_last in sparse mode.
   always_comb begin
      more_nz = 1'b0;
      for (int rr = 0; rr < M; rr++) begin
         for (int ci = 0; ci < K; ci++) begin
            if (((rr > int'(r_q)) || ((rr == int'(r_q)) && (ci > int'(cc_q)))) &&
                (acc_q[rr][ci] != '0)) begin
               more_nz = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      a_cnt_d   = a_cnt_q;
      b_cnt_d   = b_cnt_q;
      a_done_d  = a_done_q;
      b_done_d  = b_done_q;
      i_d       = i_q;
      j_d       = j_q;
      r_d       = r_q;
      cc_d      = cc_q;
      done_d    = 1'b0;
      err_idx_d = err_idx_q;
      err_ovf_d = err_ovf_q;
      a_store   = 1'b0;
      b_store   = 1'b0;
      acc_clr   = 1'b0;
      acc_we    = 1'b0;
      c_valid_o = 1'b0;
      c_last_o  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d   = StLoad;
               a_cnt_d   = '0;
               b_cnt_d   = '0;
               a_done_d  = 1'b0;
               b_done_d  = 1'b0;
               i_d       = '0;
               j_d       = '0;
               r_d       = '0;
               cc_d      = '0;
               err_idx_d = 1'b0;
               err_ovf_d = 1'b0;
               acc_clr   = 1'b1;
            end
         end
         StLoad: begin
            if (a_fire) begin
               if (!a_in_range) begin
                  err_idx_d = 1'b1;
               end else if (a_cnt_q == NnzMax) begin
                  err_ovf_d = 1'b1;
               end else begin
                  a_store = 1'b1;
                  a_cnt_d = a_cnt_q + 1'b1;
               end
               if (a_last_i) a_done_d = 1'b1;
            end
            if (b_fire) begin
               if (!b_in_range) begin
                  err_idx_d = 1'b1;
               end else if (b_cnt_q == NnzMax) begin
                  err_ovf_d = 1'b1;
               end else begin
                  b_store = 1'b1;
                  b_cnt_d = b_cnt_q + 1'b1;
               end
               if (b_last_i) b_done_d = 1'b1;
            end
            if (a_done_d && b_done_d) state_d = StCompute;
         end
         StCompute: begin
            if ((a_cnt_q == '0) || (b_cnt_q == '0)) begin
               state_d = StDrain;
            end else begin
               acc_we = (a_col_q[i_q] == b_row_q[j_q]);
               if (j_q == j_last) begin
                  j_d = '0;
                  if (i_q == i_last) begin
                     i_d     = '0;
                     state_d = StDrain;
                  end else begin
                     i_d = i_q + 1'b1;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         StDrain: begin
            c_valid_o = (SPARSE_OUT == 0) || (cur_val != '0);
            c_last_o  = c_valid_o && ((SPARSE_OUT == 0) ? at_end : !more_nz);
            // A skipped zero advances without waiting on c_ready.
            if (!c_valid_o || c_ready_i) begin
               if (at_end || c_last_o) begin
                  state_d = StIdle;
                  done_d  = 1'b1;
               end else if (cc_q == KLast) begin
                  cc_d = '0;
                  r_d  = r_q + 1'b1;
               end else begin
                  cc_d = cc_q + 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         a_cnt_q   <= '0;
         b_cnt_q   <= '0;
         a_done_q  <= 1'b0;
         b_done_q  <= 1'b0;
         i_q       <= '0;
         j_q       <= '0;
         r_q       <= '0;
         cc_q      <= '0;
         done_q    <= 1'b0;
         err_idx_q <= 1'b0;
         err_ovf_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_cnt_q   <= a_cnt_d;
         b_cnt_q   <= b_cnt_d;
         a_done_q  <= a_done_d;
         b_done_q  <= b_done_d;
         i_q       <= i_d;
         j_q       <= j_d;
         r_q       <= r_d;
         cc_q      <= cc_d;
         done_q    <= done_d;
         err_idx_q <= err_idx_d;
         err_ovf_q <= err_ovf_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int rr = 0; rr < M; rr++) begin
            for (int ci = 0; ci < K; ci++) acc_q[rr][ci] <= '0;
         end
      end else if (acc_clr) begin
         for (int rr = 0; rr < M; rr++) begin
            for (int ci = 0; ci < K; ci++) acc_q[rr][ci] <= '0;
         end
      end else if (acc_we) begin
         acc_q[acc_row][acc_col] <= acc_q[acc_row][acc_col] + prod_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (a_store) begin
         a_row_q[IW'(a_cnt_q)] <= a_row_i;
         a_col_q[IW'(a_cnt_q)] <= a_col_i;
         a_val_q[IW'(a_cnt_q)] <= a_val_i;
      end
      if (b_store) begin
         b_row_q[IW'(b_cnt_q)] <= b_row_i;
         b_col_q[IW'(b_cnt_q)] <= b_col_i;
         b_val_q[IW'(b_cnt_q)] <= b_val_i;
      end
   end

   assign busy_o         = (state_q != StIdle);
   assign done_o         = done_q;
   assign err_index_o    = err_idx_q;
   assign err_overflow_o = err_ovf_q;
   assign c_row_o        = r_q;
   assign c_col_o        = cc_q;
   assign c_val_o        = cur_val;

endmodule

// File: tb/tb_sparse_coo_mm_engine.sv
// Bench for sparse_coo_mm_engine: a dense 4x4x4 instance and a sparse-output 4x4x3 instance
// share the input streams; a reference product fills a beat scoreboard per job.
module tb_sparse_coo_mm_engine;

   typedef struct {
      int row;
      int col;
      int val;
   } ent_t;

   typedef struct {
      logic [1:0]         row;
      logic [1:0]         col;
      logic signed [33:0] val;
      logic               last;
   } beat_t;

   logic clk, rst_n, start0, start1;
   logic a_valid, a_last, b_valid, b_last, c_ready;
   logic [1:0] a_row, a_col, b_row, b_col;
   logic [15:0] a_val, b_val;

   logic d0_busy, d0_done, d0_a_ready, d0_b_ready, d0_c_valid, d0_c_last, d0_erri, d0_erro;
   logic d1_busy, d1_done, d1_a_ready, d1_b_ready, d1_c_valid, d1_c_last, d1_erri, d1_erro;
   logic [1:0]  d0_c_row, d0_c_col, d1_c_row, d1_c_col;
   logic [33:0] d0_c_val, d1_c_val;

   bit sel;
   logic bsy, dn, a_rdy, b_rdy, c_vld, c_lst, erri, erro;
   logic [1:0]  c_row_m, c_col_m;
   logic [33:0] c_val_m;

   assign bsy     = sel ? d1_busy : d0_busy;
   assign dn      = sel ? d1_done : d0_done;
   assign a_rdy   = sel ? d1_a_ready : d0_a_ready;
   assign b_rdy   = sel ? d1_b_ready : d0_b_ready;
   assign c_vld   = sel ? d1_c_valid : d0_c_valid;
   assign c_lst   = sel ? d1_c_last : d0_c_last;
   assign c_row_m = sel ? d1_c_row : d0_c_row;
   assign c_col_m = sel ? d1_c_col : d0_c_col;
   assign c_val_m = sel ? d1_c_val : d0_c_val;
   assign erri    = sel ? d1_erri : d0_erri;
   assign erro    = sel ? d1_erro : d0_erro;

   int n_tests = 0;
   int n_fail  = 0;

   ent_t  a_list[$];
   ent_t  b_list[$];
   beat_t exp_q[$];
   bit    exp_err_idx, exp_err_ovf;

   sparse_coo_mm_engine #(.K(4), .SPARSE_OUT(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start_i(start0), .busy_o(d0_busy), .done_o(d0_done),
      .a_valid_i(a_valid), .a_ready_o(d0_a_ready), .a_row_i(a_row), .a_col_i(a_col),
      .a_val_i(a_val), .a_last_i(a_last),
      .b_valid_i(b_valid), .b_ready_o(d0_b_ready), .b_row_i(b_row), .b_col_i(b_col),
      .b_val_i(b_val), .b_last_i(b_last),
      .c_valid_o(d0_c_valid), .c_ready_i(c_ready), .c_row_o(d0_c_row), .c_col_o(d0_c_col),
      .c_val_o(d0_c_val), .c_last_o(d0_c_last),
      .err_index_o(d0_erri), .err_overflow_o(d0_erro)
   );

   sparse_coo_mm_engine #(.K(3), .SPARSE_OUT(1)) u_dut_sparse (
      .clk(clk), .rst_n(rst_n), .start_i(start1), .busy_o(d1_busy), .done_o(d1_done),
      .a_valid_i(a_valid), .a_ready_o(d1_a_ready), .a_row_i(a_row), .a_col_i(a_col),
      .a_val_i(a_val), .a_last_i(a_last),
      .b_valid_i(b_valid), .b_ready_o(d1_b_ready), .b_row_i(b_row), .b_col_i(b_col),
      .b_val_i(b_val), .b_last_i(b_last),
      .c_valid_o(d1_c_valid), .c_ready_i(c_ready), .c_row_o(d1_c_row), .c_col_o(d1_c_col),
      .c_val_o(d1_c_val), .c_last_o(d1_c_last),
      .err_index_o(d1_erri), .err_overflow_o(d1_erro)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation still running, required to finish");
      $fatal(1, "watchdog expired");
   end

   // Reference product: drop out-of-range entries, keep the first 30 in-range ones, wrap at 34 bits.
   function automatic void build_expected(input bit s);
      logic signed [33:0] g [4][4];
      ent_t  ka[$];
      ent_t  kb[$];
      beat_t bt;
      int    kk;
      kk = s ? 3 : 4;
      exp_err_idx = 1'b0;
      exp_err_ovf = 1'b0;
      exp_q.delete();
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) g[r][c] = '0;
      foreach (a_list[k]) begin
         if (a_list[k].row >= 4 || a_list[k].col >= 4) exp_err_idx = 1'b1;
         else if (ka.size() >= 30) exp_err_ovf = 1'b1;
         else ka.push_back(a_list[k]);
      end
      foreach (b_list[k]) begin
         if (b_list[k].row >= 4 || b_list[k].col >= kk) exp_err_idx = 1'b1;
         else if (kb.size() >= 30) exp_err_ovf = 1'b1;
         else kb.push_back(b_list[k]);
      end
      foreach (ka[x]) foreach (kb[y]) begin
         if (ka[x].col == kb[y].row)
            g[ka[x].row][kb[y].col] = g[ka[x].row][kb[y].col] +
                                      34'(longint'(ka[x].val) * longint'(kb[y].val));
      end
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < kk; c++) begin
            if (!s || g[r][c] != 0) begin
               bt.row  = 2'(r);
               bt.col  = 2'(c);
               bt.val  = g[r][c];
               bt.last = 1'b0;
               exp_q.push_back(bt);
            end
         end
      end
      if (exp_q.size() > 0) exp_q[exp_q.size() - 1].last = 1'b1;
   endfunction

   function automatic void gen_lists(input bit s, input int na, input int nb);
      a_list.delete();
      b_list.delete();
      for (int k = 0; k < na; k++)
         a_list.push_back('{row: int'($urandom_range(0, 3)), col: int'($urandom_range(0, 3)),
                            val: int'($urandom_range(0, 200)) - 100});
      for (int k = 0; k < nb; k++)
         b_list.push_back('{row: int'($urandom_range(0, 3)),
                            col: int'($urandom_range(0, s ? 2 : 3)),
                            val: int'($urandom_range(0, 200)) - 100});
   endfunction

   task automatic send_a(input int gap_pct);
      int cyc;
      bit hs;
      for (int k = 0; k < a_list.size(); k++) begin
         while ($urandom_range(0, 99) < gap_pct) begin @(posedge clk); #1; end
         a_valid = 1'b1;
         a_row   = 2'(a_list[k].row);
         a_col   = 2'(a_list[k].col);
         a_val   = 16'(a_list[k].val);
         a_last  = (k == a_list.size() - 1);
         hs = 1'b0;
         cyc = 0;
         while (!hs && cyc < 1000) begin
            @(negedge clk); hs = a_rdy; @(posedge clk); #1; cyc++;
         end
         a_valid = 1'b0;
         a_last  = 1'b0;
         if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL a_handshake entry %0d: a_ready got 0 for 1000 cycles, required 1", k);
            return;
         end
      end
   endtask

   task automatic send_b(input int gap_pct);
      int cyc;
      bit hs;
      for (int k = 0; k < b_list.size(); k++) begin
         while ($urandom_range(0, 99) < gap_pct) begin @(posedge clk); #1; end
         b_valid = 1'b1;
         b_row   = 2'(b_list[k].row);
         b_col   = 2'(b_list[k].col);
         b_val   = 16'(b_list[k].val);
         b_last  = (k == b_list.size() - 1);
         hs = 1'b0;
         cyc = 0;
         while (!hs && cyc < 1000) begin
            @(negedge clk); hs = b_rdy; @(posedge clk); #1; cyc++;
         end
         b_valid = 1'b0;
         b_last  = 1'b0;
         if (!hs) begin
            n_tests++; n_fail++;
            $display("FAIL b_handshake entry %0d: b_ready got 0 for 1000 cycles, required 1", k);
            return;
         end
      end
   endtask

   task automatic drain(input int rdy_pct, input int budget);
      int    cyc, last_hs;
      bit    got_done, stall, had_beats;
      beat_t e, held;
      cyc = 0; last_hs = -10; got_done = 1'b0; stall = 1'b0;
      had_beats = (exp_q.size() > 0);
      while (!got_done && cyc < budget) begin
         c_ready = ($urandom_range(0, 99) < rdy_pct);
         @(negedge clk);
         if (stall) begin
            n_tests++;
            if (c_vld !== 1'b1 || c_row_m !== held.row || c_col_m !== held.col ||
                c_val_m !== held.val || c_lst !== held.last) begin
               n_fail++;
               $display("FAIL stall_stable: got v=%0b (%0d,%0d,%0d) required v=1 (%0d,%0d,%0d)",
                        c_vld, c_row_m, c_col_m, $signed(c_val_m), held.row, held.col, held.val);
            end
         end
         stall = 1'b0;
         if (c_vld === 1'b1) begin
            if (c_ready) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL extra_beat: got (%0d,%0d,%0d), required no beat",
                           c_row_m, c_col_m, $signed(c_val_m));
               end else begin
                  e = exp_q.pop_front();
                  if (c_row_m !== e.row || c_col_m !== e.col || c_val_m !== e.val ||
                      c_lst !== e.last) begin
                     n_fail++;
                     $display("FAIL c_beat: got (%0d,%0d,%0d,last=%0b) required (%0d,%0d,%0d,last=%0b)",
                              c_row_m, c_col_m, $signed(c_val_m), c_lst,
                              e.row, e.col, e.val, e.last);
                  end
               end
               if (c_lst === 1'b1) last_hs = cyc;
            end else begin
               stall = 1'b1;
               held.row = c_row_m; held.col = c_col_m; held.val = c_val_m; held.last = c_lst;
            end
         end
         if (dn === 1'b1) begin
            got_done = 1'b1;
            if (had_beats) begin
               n_tests++;
               if (cyc != last_hs + 1) begin
                  n_fail++;
                  $display("FAIL done_timing: got done at cycle %0d, required %0d", cyc, last_hs + 1);
               end
            end
            n_tests++;
            if (bsy !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_at_done: got %0b, required 0", bsy);
            end
         end
         @(posedge clk); #1; cyc++;
      end
      c_ready = 1'b0;
      n_tests++;
      if (!got_done) begin
         n_fail++;
         $display("FAIL done_timeout: got no done in %0d cycles, required a done pulse", budget);
      end
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL missing_beats: got %0d beats outstanding, required 0", exp_q.size());
      end
      @(negedge clk);
      n_tests++;
      if (dn !== 1'b0) begin
         n_fail++;
         $display("FAIL done_width: got done=%0b a cycle later, required 0", dn);
      end
      n_tests++;
      if (erri !== exp_err_idx || erro !== exp_err_ovf) begin
         n_fail++;
         $display("FAIL err_flags: got idx=%0b ovf=%0b, required idx=%0b ovf=%0b",
                  erri, erro, exp_err_idx, exp_err_ovf);
      end
   endtask

   task automatic pulse_start(input bit s);
      sel = s;
      @(posedge clk); #1;
      if (s) start1 = 1'b1; else start0 = 1'b1;
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   task automatic run_job(input bit s, input int gap_pct, input int rdy_pct);
      build_expected(s);
      c_ready = 1'b0;
      pulse_start(s);
      n_tests++;
      if (bsy !== 1'b1 || erri !== 1'b0 || erro !== 1'b0) begin
         n_fail++;
         $display("FAIL start_state: got busy=%0b idx=%0b ovf=%0b, required busy=1 idx=0 ovf=0",
                  bsy, erri, erro);
      end
      fork
         send_a(gap_pct);
         send_b(gap_pct);
         drain(rdy_pct, 4000);
      join
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({d0_busy, d0_done, d0_a_ready, d0_b_ready, d0_c_valid, d0_c_last, d0_erri, d0_erro}
          !== 8'h00 || d0_c_val !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_dense: got ctrl=%b val=%0d, required all 0",
                  {d0_busy, d0_done, d0_a_ready, d0_b_ready, d0_c_valid, d0_c_last, d0_erri,
                   d0_erro}, d0_c_val);
      end
      n_tests++;
      if ({d1_busy, d1_done, d1_a_ready, d1_b_ready, d1_c_valid, d1_c_last, d1_erri, d1_erro}
          !== 8'h00 || d1_c_val !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_sparse: got ctrl=%b val=%0d, required all 0",
                  {d1_busy, d1_done, d1_a_ready, d1_b_ready, d1_c_valid, d1_c_last, d1_erri,
                   d1_erro}, d1_c_val);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_tests++;
      if (d0_busy !== 1'b0 || d0_a_ready !== 1'b0 || d0_c_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%0b a_ready=%0b c_valid=%0b, required 0",
                  d0_busy, d0_a_ready, d0_c_valid);
      end
   endtask

   task automatic test_identity();
      a_list.delete(); b_list.delete();
      for (int k = 0; k < 4; k++) a_list.push_back('{row: k, col: k, val: 1});
      b_list.push_back('{row: 0, col: 1, val: 5});
      b_list.push_back('{row: 2, col: 3, val: -7});
      run_job(1'b0, 0, 100);
   endtask

   task automatic test_accumulate();
      a_list.delete(); b_list.delete();
      a_list.push_back('{row: 1, col: 0, val: 3});
      a_list.push_back('{row: 1, col: 2, val: 4});
      b_list.push_back('{row: 0, col: 2, val: 2});
      b_list.push_back('{row: 2, col: 2, val: 10});
      run_job(1'b1, 0, 100);
   endtask

   task automatic test_backpressure();
      for (int it = 0; it < 4; it++) begin
         gen_lists(it[0], int'($urandom_range(1, 12)), int'($urandom_range(1, 12)));
         run_job(it[0], 40, 50);
      end
   endtask

   task automatic test_errors();
      a_list.delete(); b_list.delete();
      for (int k = 0; k < 31; k++) a_list.push_back('{row: k % 4, col: (k / 4) % 4, val: k + 1});
      b_list.push_back('{row: 3, col: 0, val: 1});
      b_list.push_back('{row: 1, col: 1, val: 2});
      b_list.push_back('{row: 0, col: 3, val: 9});
      run_job(1'b1, 10, 80);
      n_tests++;
      if (erri !== 1'b1 || erro !== 1'b1) begin
         n_fail++;
         $display("FAIL err_sticky: got idx=%0b ovf=%0b, required 1 1", erri, erro);
      end
      gen_lists(1'b1, 3, 3);
      run_job(1'b1, 0, 100);
   endtask

   task automatic test_wrap();
      a_list.delete(); b_list.delete();
      a_list.push_back('{row: 0, col: 0, val: -32768});
      for (int k = 0; k < 5; k++) b_list.push_back('{row: 0, col: 0, val: -32768});
      run_job(1'b0, 0, 70);
      for (int k = 0; k < 5; k++) a_list.push_back('{row: 0, col: 0, val: -32768});
      run_job(1'b0, 20, 70);
   endtask

   task automatic test_reset_mid();
      gen_lists(1'b0, 6, 5);
      pulse_start(1'b0);
      fork
         send_a(0);
         send_b(0);
      join
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bsy !== 1'b0 || c_vld !== 1'b0 || dn !== 1'b0 || a_rdy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got busy=%0b c_valid=%0b done=%0b a_ready=%0b, required 0",
                  bsy, c_vld, dn, a_rdy);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         n_tests++;
         if (dn !== 1'b0 || bsy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_done: got done=%0b busy=%0b, required 0 0", dn, bsy);
         end
      end
      gen_lists(1'b0, 5, 6);
      run_job(1'b0, 20, 60);
   endtask

   initial begin
      rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; sel = 1'b0;
      a_valid = 1'b0; a_last = 1'b0; a_row = '0; a_col = '0; a_val = '0;
      b_valid = 1'b0; b_last = 1'b0; b_row = '0; b_col = '0; b_val = '0;
      c_ready = 1'b0;
      test_reset();
      test_identity();
      test_accumulate();
      test_backpressure();
      test_errors();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
